// File: rtl/vram_arbiter_if.sv
// Client and RAM-side bundle for vram_arbiter: CPU, tile and sprite ports plus the single-port VRAM.
interface vram_arbiter_if #(
  parameter int ADDR_W = 13
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;
  logic              cpu_ack;

  logic              tile_req;
  logic [ADDR_W-1:0] tile_addr;
  logic [7:0]        tile_dout;
  logic              tile_valid;

  logic              spr_req;
  logic [ADDR_W-1:0] spr_addr;
  logic [7:0]        spr_dout;
  logic              spr_valid;

  logic [ADDR_W-1:0] vram_addr;
  logic              vram_we;
  logic [7:0]        vram_din;
  logic [7:0]        vram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack,
    input  tile_req, tile_addr,
    output tile_dout, tile_valid,
    input  spr_req, spr_addr,
    output spr_dout, spr_valid,
    output vram_addr, vram_we, vram_din,
    input  vram_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack,
    output tile_req, tile_addr,
    input  tile_dout, tile_valid,
    output spr_req, spr_addr,
    input  spr_dout, spr_valid,
    input  vram_addr, vram_we, vram_din,
    output vram_dout
  );
endinterface

// File: rtl/vram_arbiter.sv
// Slot-based VRAM arbiter sharing one single-port RAM between tile fetch, sprite fetch and CPU.
// Optional macro VRAM_CPU_BURST_EN: during vblank a pending CPU access is granted in any idle cycle.
module vram_arbiter #(
  parameter int ADDR_W = 13
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       hb,
  input  logic       vb,
  input  logic [8:0] hcount,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {CPU_IDLE, CPU_PEND, CPU_ISSUED, CPU_DONE} cpu_st_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_TILE, OWN_CPU, OWN_SPR} own_e;

  cpu_st_e           cpu_st_q, cpu_st_d;
  own_e              s1_own_q, s1_own_d;
  own_e              s2_own_q, s2_own_d;
  logic              cpu_we_l_q, cpu_we_l_d;
  logic [ADDR_W-1:0] cpu_addr_l_q, cpu_addr_l_d;
  logic [7:0]        cpu_din_l_q, cpu_din_l_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic              vram_we_q, vram_we_d;
  logic [7:0]        vram_din_q, vram_din_d;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
  logic [7:0]        tile_dout_q, tile_dout_d;
  logic [7:0]        spr_dout_q, spr_dout_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              tile_valid_q, tile_valid_d;
  logic              spr_valid_q, spr_valid_d;

  own_e slot_owner;
  own_e grant;
  logic cpu_pend;
  logic busy;
  logic decide;
  logic unused_hcount;

  assign unused_hcount = ^hcount[8:2];

  always_comb begin
    slot_owner = OWN_CPU;
    if (vb) begin
      slot_owner = OWN_CPU;
    end else if (hb) begin
      slot_owner = hcount[0] ? OWN_SPR : OWN_CPU;
    end else begin
      case (hcount[1:0])
        2'd0, 2'd1: slot_owner = OWN_TILE;
        2'd2:       slot_owner = OWN_CPU;
        default:    slot_owner = OWN_SPR;
      endcase
    end
  end

  // Any access still in the two-stage pipe blocks a new decision.
  always_comb begin
    cpu_pend = (cpu_st_q == CPU_PEND);
    busy     = (s1_own_q != OWN_NONE) || (s2_own_q != OWN_NONE);
`ifdef VRAM_CPU_BURST_EN
    decide   = !busy && (ce_pix || (vb && cpu_pend));
`else
    decide   = !busy && ce_pix;
`endif
    grant = OWN_NONE;
    if (decide) begin
      if ((slot_owner == OWN_TILE && bus.tile_req) ||
          (slot_owner == OWN_SPR  && bus.spr_req)) begin
        grant = slot_owner;
      end else if (cpu_pend) begin
        grant = OWN_CPU;
      end
    end
  end

  always_comb begin
    cpu_st_d     = cpu_st_q;
    cpu_we_l_d   = cpu_we_l_q;
    cpu_addr_l_d = cpu_addr_l_q;
    cpu_din_l_d  = cpu_din_l_q;
    vram_addr_d  = vram_addr_q;
    vram_we_d    = 1'b0;
    vram_din_d   = vram_din_q;
    cpu_dout_d   = cpu_dout_q;
    tile_dout_d  = tile_dout_q;
    spr_dout_d   = spr_dout_q;
    cpu_ack_d    = 1'b0;
    tile_valid_d = 1'b0;
    spr_valid_d  = 1'b0;
    s1_own_d     = grant;
    s2_own_d     = s1_own_q;

    case (grant)
      OWN_TILE: vram_addr_d = bus.tile_addr;
      OWN_SPR:  vram_addr_d = bus.spr_addr;
      OWN_CPU: begin
        vram_addr_d = cpu_addr_l_q;
        vram_we_d   = cpu_we_l_q;
        if (cpu_we_l_q) vram_din_d = cpu_din_l_q;
      end
      default: ;
    endcase

    // RAM data for the access granted two edges ago is on vram_dout now.
    case (s2_own_q)
      OWN_TILE: begin
        tile_dout_d  = bus.vram_dout;
        tile_valid_d = 1'b1;
      end
      OWN_SPR: begin
        spr_dout_d  = bus.vram_dout;
        spr_valid_d = 1'b1;
      end
      OWN_CPU: begin
        cpu_ack_d = 1'b1;
        if (!cpu_we_l_q) cpu_dout_d = bus.vram_dout;
      end
      default: ;
    endcase

    case (cpu_st_q)
      CPU_IDLE: begin
        if (bus.cpu_req) begin
          cpu_st_d     = CPU_PEND;
          cpu_we_l_d   = bus.cpu_we;
          cpu_addr_l_d = bus.cpu_addr;
          cpu_din_l_d  = bus.cpu_din;
        end
      end
      CPU_PEND:   if (grant == OWN_CPU) cpu_st_d = CPU_ISSUED;
      CPU_ISSUED: if (s2_own_q == OWN_CPU) cpu_st_d = CPU_DONE;
      default:    if (!bus.cpu_req) cpu_st_d = CPU_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_st_q     <= CPU_IDLE;
      s1_own_q     <= OWN_NONE;
      s2_own_q     <= OWN_NONE;
      cpu_we_l_q   <= 1'b0;
      cpu_addr_l_q <= '0;
      cpu_din_l_q  <= '0;
      vram_addr_q  <= '0;
      vram_we_q    <= 1'b0;
      vram_din_q   <= '0;
      cpu_dout_q   <= '0;
      tile_dout_q  <= '0;
      spr_dout_q   <= '0;
      cpu_ack_q    <= 1'b0;
      tile_valid_q <= 1'b0;
      spr_valid_q  <= 1'b0;
    end else begin
      cpu_st_q     <= cpu_st_d;
      s1_own_q     <= s1_own_d;
      s2_own_q     <= s2_own_d;
      cpu_we_l_q   <= cpu_we_l_d;
      cpu_addr_l_q <= cpu_addr_l_d;
      cpu_din_l_q  <= cpu_din_l_d;
      vram_addr_q  <= vram_addr_d;
      vram_we_q    <= vram_we_d;
      vram_din_q   <= vram_din_d;
      cpu_dout_q   <= cpu_dout_d;
      tile_dout_q  <= tile_dout_d;
      spr_dout_q   <= spr_dout_d;
      cpu_ack_q    <= cpu_ack_d;
      tile_valid_q <= tile_valid_d;
      spr_valid_q  <= spr_valid_d;
    end
  end

  assign bus.vram_addr  = vram_addr_q;
  assign bus.vram_we    = vram_we_q;
  assign bus.vram_din   = vram_din_q;
  assign bus.cpu_dout   = cpu_dout_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.tile_dout  = tile_dout_q;
  assign bus.tile_valid = tile_valid_q;
  assign bus.spr_dout   = spr_dout_q;
  assign bus.spr_valid  = spr_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter with a slot-table reference model; define VRAM_CPU_BURST_EN to match a burst build.
module tb_vram_arbiter;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int W_NONE = -1;
  localparam int W_TILE = 0;
  localparam int W_CPU  = 1;
  localparam int W_SPR  = 2;

  logic       clk_sys;
  logic       reset;
  logic       ce_pix;
  logic       hb;
  logic       vb;
  logic [8:0] hcount;

  vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce_pix  (ce_pix),
    .hb      (hb),
    .vb      (vb),
    .hcount  (hcount),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Slot owner per line region (active, hblank, vblank) and phase.
  int slot_tbl [3][4] = '{'{W_TILE, W_TILE, W_CPU, W_SPR},
                          '{W_CPU,  W_SPR,  W_CPU, W_SPR},
                          '{W_CPU,  W_CPU,  W_CPU, W_CPU}};

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37) ^ (a >> 4));
  endfunction

  // Environment RAM: unwritten locations read a fixed address-derived pattern.
  logic [7:0] ram [DEPTH];
  logic       wr_flag [DEPTH];
  logic [7:0] ram_dout_q;
  logic       ram_clr;

  function automatic logic [7:0] ram_peek(input int a);
    return wr_flag[a] ? ram[a] : init_byte(a);
  endfunction

  always @(posedge clk_sys) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) wr_flag[i] <= 1'b0;
      ram_dout_q <= '0;
    end else begin
      if (bus.vram_we) begin
        ram[bus.vram_addr]     <= bus.vram_din;
        wr_flag[bus.vram_addr] <= 1'b1;
      end
      ram_dout_q <= ram_peek(int'(bus.vram_addr));
    end
  end
  assign bus.vram_dout = ram_dout_q;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tk    = 0;
  int dut_acks = 0;
  bit fix_tile = 1'b0;

  logic [7:0]        shadow [DEPTH];
  logic [ADDR_W-1:0] e_addr;
  logic              e_we, e_ack, e_tv, e_sv;
  logic [7:0]        e_din, e_cpu_dout, e_tile_dout, e_spr_dout;

  bit                fl_on = 1'b0;
  int                fl_edge = 0;
  int                fl_who = W_NONE;
  bit                fl_we = 1'b0;
  logic [7:0]        fl_data;

  int                cpu_st = 0;   // 0 none, 1 waiting, 2 granted, 3 acked awaiting release
  logic              cpu_l_we;
  logic [ADDR_W-1:0] cpu_l_addr;
  logic [7:0]        cpu_l_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Predicts what the clock edge about to happen does, from the inputs now driven.
  task automatic model_edge();
    int  old_st;
    int  who;
    int  own;
    bit  decide;
    bit  cpu_done;
    logic [ADDR_W-1:0] a;
    e_we  = 1'b0;
    e_ack = 1'b0;
    e_tv  = 1'b0;
    e_sv  = 1'b0;
    if (reset) begin
      e_addr = '0; e_din = '0; e_cpu_dout = '0; e_tile_dout = '0; e_spr_dout = '0;
      fl_on  = 1'b0;
      cpu_st = 0;
      return;
    end
    old_st = cpu_st;
    decide = !fl_on && ce_pix;
`ifdef VRAM_CPU_BURST_EN
    decide = decide || (!fl_on && vb && old_st == 1);
`endif
    who = W_NONE;
    if (decide) begin
      own = slot_tbl[vb ? 2 : (hb ? 1 : 0)][hcount[1:0]];
      if ((own == W_TILE && bus.tile_req) || (own == W_SPR && bus.spr_req)) who = own;
      else if (old_st == 1) who = W_CPU;
    end
    cpu_done = 1'b0;
    if (fl_on && cyc == fl_edge + 2) begin
      case (fl_who)
        W_TILE: begin e_tv = 1'b1; e_tile_dout = fl_data; end
        W_SPR:  begin e_sv = 1'b1; e_spr_dout = fl_data; end
        default: begin
          e_ack = 1'b1;
          if (!fl_we) e_cpu_dout = fl_data;
          cpu_done = 1'b1;
        end
      endcase
      fl_on = 1'b0;
    end
    if (who != W_NONE) begin
      a = (who == W_TILE) ? bus.tile_addr : ((who == W_SPR) ? bus.spr_addr : cpu_l_addr);
      fl_on   = 1'b1;
      fl_edge = cyc;
      fl_who  = who;
      fl_we   = (who == W_CPU) && cpu_l_we;
      fl_data = shadow[a];
      e_addr  = a;
      e_we    = fl_we;
      if (fl_we) begin
        e_din     = cpu_l_din;
        shadow[a] = cpu_l_din;
      end
    end
    case (old_st)
      0: if (bus.cpu_req) begin
        cpu_st = 1;
        cpu_l_we = bus.cpu_we; cpu_l_addr = bus.cpu_addr; cpu_l_din = bus.cpu_din;
      end
      1: if (who == W_CPU) cpu_st = 2;
      2: if (cpu_done) cpu_st = 3;
      default: if (!bus.cpu_req) cpu_st = 0;
    endcase
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_sys);
    #1;
    chk("vram_we", 32'(bus.vram_we), 32'(e_we));
    chk("vram_addr", 32'(bus.vram_addr), 32'(e_addr));
    if (e_we) chk("vram_din", 32'(bus.vram_din), 32'(e_din));
    chk("cpu_ack", 32'(bus.cpu_ack), 32'(e_ack));
    chk("tile_valid", 32'(bus.tile_valid), 32'(e_tv));
    chk("spr_valid", 32'(bus.spr_valid), 32'(e_sv));
    chk("cpu_dout", 32'(bus.cpu_dout), 32'(e_cpu_dout));
    chk("tile_dout", 32'(bus.tile_dout), 32'(e_tile_dout));
    chk("spr_dout", 32'(bus.spr_dout), 32'(e_spr_dout));
    if (bus.cpu_ack === 1'b1) dut_acks++;
    cyc++;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    int r;
    r = int'($urandom_range(15));
    return ($urandom_range(1) == 0) ? ADDR_W'(r) : ADDR_W'(DEPTH - 1 - r);
  endfunction

  // vmode: 0 active, 1 hblank, 2 vblank. pt/ps: request percentages. pc < 0 leaves the CPU port untouched.
  task automatic cycle1(input int vmode, input int pt, input int ps, input int pc);
    ce_pix = (tk % 4 == 0);
    tk++;
    vb = (vmode == 2);
    hb = (vmode == 2) ? 1'($urandom_range(1)) : (vmode == 1);
    bus.tile_req  = ($urandom_range(99) < pt);
    bus.spr_req   = ($urandom_range(99) < ps);
    bus.tile_addr = fix_tile ? ADDR_W'(16'h0100) : rand_addr();
    bus.spr_addr  = rand_addr();
    if (pc >= 0) begin
      if (cpu_st == 0 && !bus.cpu_req) begin
        if ($urandom_range(99) < pc) begin
          bus.cpu_req  = 1'b1;
          bus.cpu_we   = 1'($urandom_range(1));
          bus.cpu_addr = rand_addr();
          bus.cpu_din  = 8'($urandom);
        end
      end else if (cpu_st == 3 && bus.cpu_req) begin
        if ($urandom_range(1) == 0) bus.cpu_req = 1'b0;
      end else begin
        bus.cpu_addr = rand_addr();
        bus.cpu_din  = 8'($urandom);
      end
    end
    step();
    if (ce_pix) hcount = (hcount == 9'd383) ? 9'd0 : hcount + 9'd1;
  endtask

  task automatic run(input int vmode, input int n, input int pt, input int ps, input int pc);
    for (int i = 0; i < n; i++) cycle1(vmode, pt, ps, pc);
  endtask

  task automatic cpu_start(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_addr = a;
    bus.cpu_din  = d;
  endtask

  initial begin
    int base;
    int start;
    int lat;
    bit seen;
    bit found;
    reset = 1'b1; ce_pix = 1'b0; hb = 1'b0; vb = 1'b0; hcount = 9'd380; ram_clr = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.tile_req = 1'b0; bus.tile_addr = '0; bus.spr_req = 1'b0; bus.spr_addr = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_byte(i);
    step();
    step();
    ram_clr = 1'b0;
    reset   = 1'b0;

    // Tile fetch of 0x0100 starting at phase 0 of an active line.
    fix_tile = 1'b1;
    run(0, 8, 100, 0, 0);
    fix_tile = 1'b0;

    // CPU write 0x55 to the top address with tile/sprite idle.
    cpu_start(1'b1, ADDR_W'(16'h1FFF), 8'h55);
    run(0, 12, 0, 0, -1);
    chk("ram_1fff", 32'(ram_peek(DEPTH - 1)), 32'h55);
    bus.cpu_req = 1'b0;
    run(0, 4, 0, 0, -1);

    // All three clients held on an active line; CPU served once and then parked.
    base = dut_acks;
    cpu_start(1'b0, ADDR_W'(16'h0010), 8'h00);
    run(0, 24, 100, 100, -1);
    chk("active_single_ack", 32'(dut_acks - base), 32'd1);
    bus.cpu_req = 1'b0;
    run(0, 4, 0, 0, -1);

    // Hblank with a continuous sprite request and a CPU read of 0x0010.
    base = dut_acks;
    cpu_start(1'b0, ADDR_W'(16'h0010), 8'h00);
    run(1, 16, 0, 100, -1);
    chk("hblank_single_ack", 32'(dut_acks - base), 32'd1);
    chk("hblank_cpu_dout", 32'(bus.cpu_dout), 32'(shadow[16]));
    bus.cpu_req = 1'b0;
    run(1, 4, 0, 0, -1);

    run(0, 300, 40, 40, 30);
    run(1, 200, 40, 60, 30);
    run(2, 200, 50, 50, 30);
    bus.cpu_req = 1'b0;
    run(2, 8, 0, 0, -1);

    // Vblank CPU read latency measured from the edge that accepts the request.
    for (int k = 0; k < 3; k++) begin
      bus.cpu_req = 1'b0;
      run(2, 3 + k, 0, 0, -1);
      start = cyc;
      base  = dut_acks;
      cpu_start(1'b0, rand_addr(), 8'h00);
      seen = 1'b0;
      lat  = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        cycle1(2, 0, 0, -1);
        if (dut_acks != base) begin
          seen = 1'b1;
          lat  = (cyc - 1) - start;
        end
      end
      chk("vblank_ack_seen", 32'(seen), 32'd1);
`ifdef VRAM_CPU_BURST_EN
      chk("burst_latency", 32'(lat), 32'd3);
`else
      chk("vblank_latency_bound", 32'(lat >= 3 && lat <= 6), 32'd1);
`endif
    end
    bus.cpu_req = 1'b0;
    run(2, 4, 0, 0, -1);

    // Reset during the cycle after a CPU read grant; held request is re-served.
    cpu_start(1'b0, ADDR_W'(16'h0020), 8'h00);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (fl_on && fl_who == W_CPU && cyc == fl_edge + 1) found = 1'b1;
      else cycle1(2, 0, 0, -1);
    end
    chk("reset_window_found", 32'(found), 32'd1);
    base  = dut_acks;
    reset = 1'b1;
    cycle1(2, 0, 0, -1);
    reset = 1'b0;
    run(2, 3, 0, 0, -1);
    chk("no_ack_across_reset", 32'(dut_acks - base), 32'd0);
    run(2, 12, 0, 0, -1);
    chk("reserved_after_reset", 32'(dut_acks - base), 32'd1);
    bus.cpu_req = 1'b0;
    run(0, 40, 50, 50, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
